// File: rtl/urv_writeback_pkg.sv
// Shared constants, FSM encoding and stage payload for the uRV writeback stage.
// Optional retired-instruction counter is enabled with KMKZ_WB_INSTRET_EN.
package urv_writeback_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RIDX_W = 5;
  localparam int unsigned FUN_W  = 3;
  localparam int unsigned CNT_W  = 64;

  localparam logic [FUN_W-1:0] KMKZ_LD_LB  = 3'b000;
  localparam logic [FUN_W-1:0] KMKZ_LD_LH  = 3'b001;
  localparam logic [FUN_W-1:0] KMKZ_LD_LW  = 3'b010;
  localparam logic [FUN_W-1:0] KMKZ_LD_LBU = 3'b100;
  localparam logic [FUN_W-1:0] KMKZ_LD_LHU = 3'b101;

  typedef enum logic {
    W_IDLE      = 1'b0,
    W_LOAD_WAIT = 1'b1
  } w_state_t;

  // Instruction held in the W stage
  typedef struct packed {
    logic              valid;
    logic              load;
    logic              rd_write;
    logic [RIDX_W-1:0] rd;
    logic [XLEN-1:0]   value;
    logic [FUN_W-1:0]  fun;
    logic [1:0]        addr;
  } wb_stage_t;

endpackage

// File: rtl/urv_writeback_load_align.sv
// Load return alignment: byte/half select by address, then sign or zero extension.
module urv_wb_load_align
  import urv_writeback_pkg::*;
(
  input  logic [XLEN-1:0]  i_data,
  input  logic [FUN_W-1:0] i_fun,
  input  logic [1:0]       i_addr,
  output logic [XLEN-1:0]  o_value
);

  logic [XLEN-1:0] w_sh;

  assign w_sh = i_data >> {i_addr, 3'b000};

  // Undefined funct3 codes fall through to a full-word load
  always_comb begin
    o_value = i_data;
    case (i_fun)
      KMKZ_LD_LB:  o_value = {{24{w_sh[7]}}, w_sh[7:0]};
      KMKZ_LD_LBU: o_value = {24'd0, w_sh[7:0]};
      KMKZ_LD_LH:  o_value = {{16{w_sh[15]}}, w_sh[15:0]};
      KMKZ_LD_LHU: o_value = {16'd0, w_sh[15:0]};
      default:     o_value = i_data;
    endcase
  end

endmodule

// File: rtl/urv_writeback.sv
// uRV W stage: registers X results, merges load returns, drives rd write and W->X bypass.
// Define KMKZ_WB_INSTRET_EN to add the 64-bit retired-instruction counter w_instret_o.
module urv_writeback
  import urv_writeback_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              x_valid_i,
  input  logic [RIDX_W-1:0] x_rd_i,
  input  logic              x_rd_write_i,
  input  logic [XLEN-1:0]   x_rd_value_i,
  input  logic              x_load_i,
  input  logic [FUN_W-1:0]  x_fun_i,
  input  logic [1:0]        x_dm_addr_i,
  input  logic [XLEN-1:0]   dm_data_l_i,
  input  logic              dm_load_done_i,
  output logic              w_stall_req_o,
  output logic              w_valid_o,
  output logic [RIDX_W-1:0] w_rd_o,
  output logic [XLEN-1:0]   w_rd_value_o,
  output logic              w_rd_store_o,
  output logic              w_bypass_rd_write_o,
`ifdef KMKZ_WB_INSTRET_EN
  output logic [XLEN-1:0]   w_bypass_rd_value_o,
  output logic [CNT_W-1:0]  w_instret_o
`else
  output logic [XLEN-1:0]   w_bypass_rd_value_o
`endif
);

  w_state_t        r_state;
  w_state_t        w_state_next;
  wb_stage_t       r_stage;
  wb_stage_t       w_x_stage;
  logic [XLEN-1:0] w_aligned;
  logic            w_done;
  logic            w_x_is_load;

  urv_wb_load_align u_align (
    .i_data  (dm_data_l_i),
    .i_fun   (r_stage.fun),
    .i_addr  (r_stage.addr),
    .o_value (w_aligned)
  );

  always_comb begin
    w_x_stage          = '0;
    w_x_stage.valid    = x_valid_i;
    w_x_stage.load     = x_load_i;
    w_x_stage.rd_write = x_rd_write_i;
    w_x_stage.rd       = x_rd_i;
    w_x_stage.value    = x_rd_value_i;
    w_x_stage.fun      = x_fun_i;
    w_x_stage.addr     = x_dm_addr_i;
  end

  assign w_x_is_load   = x_valid_i & x_load_i;
  assign w_stall_req_o = (r_state == W_LOAD_WAIT) & ~dm_load_done_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= W_IDLE;
    else        r_state <= w_state_next;
  end

  // A load completing in W lets the next instruction enter; stay put if it is also a load
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      W_IDLE:      if (w_x_is_load) w_state_next = W_LOAD_WAIT;
      W_LOAD_WAIT: if (dm_load_done_i) w_state_next = w_x_is_load ? W_LOAD_WAIT : W_IDLE;
      default:     w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)              r_stage <= '0;
    else if (!w_stall_req_o) r_stage <= w_x_stage;
  end

  assign w_done = r_stage.valid &
                  (~r_stage.load | ((r_state == W_LOAD_WAIT) & dm_load_done_i));

  assign w_valid_o           = w_done;
  assign w_rd_o              = r_stage.rd;
  assign w_rd_value_o        = r_stage.load ? w_aligned : r_stage.value;
  assign w_rd_store_o        = w_done & r_stage.rd_write & (r_stage.rd != '0);
  assign w_bypass_rd_write_o = w_rd_store_o;
  assign w_bypass_rd_value_o = w_rd_value_o;

`ifdef KMKZ_WB_INSTRET_EN
  logic [CNT_W-1:0] r_instret;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      r_instret <= '0;
    else if (w_done) r_instret <= r_instret + CNT_W'(1);
  end

  assign w_instret_o = r_instret;
`endif

endmodule
